// File: rtl/lcd_nibble_writer.sv
// Byte-to-LCD writer for the Spartan-3E character display in 4-bit mode.
// Runs the power-on init nibble sequence, then serialises accepted bytes into two timed E pulses.
module lcd_nibble_writer #(
  parameter int P_POWERUP = 750000,
  parameter int P_INIT1   = 205000,
  parameter int P_INIT2   = 5000,
  parameter int P_INIT3   = 2000,
  parameter int P_SETUP   = 2,
  parameter int P_PULSE   = 12,
  parameter int P_HOLD    = 1,
  parameter int P_GAP     = 50,
  parameter int P_CMD     = 2000,
  parameter int P_CLEAR   = 82000,
  parameter int P_CW      = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_D,
  output logic [3:0] oState
);

  // Handshake: a byte transfers on any cycle where iValid && oReady; oReady is high only in IDLE.
  typedef enum logic [3:0] {
    S_PWR_WAIT   = 4'd0,
    S_INIT_SETUP = 4'd1,
    S_INIT_PULSE = 4'd2,
    S_INIT_HOLD  = 4'd3,
    S_INIT_WAIT  = 4'd4,
    S_IDLE       = 4'd5,
    S_SETUP_HI   = 4'd6,
    S_PULSE_HI   = 4'd7,
    S_HOLD_HI    = 4'd8,
    S_GAP        = 4'd9,
    S_SETUP_LO   = 4'd10,
    S_PULSE_LO   = 4'd11,
    S_HOLD_LO    = 4'd12,
    S_POST       = 4'd13
  } lcdState_t;

  localparam logic [P_CW-1:0] L_POWERUP = P_CW'(P_POWERUP - 1);
  localparam logic [P_CW-1:0] L_INIT1   = P_CW'(P_INIT1 - 1);
  localparam logic [P_CW-1:0] L_INIT2   = P_CW'(P_INIT2 - 1);
  localparam logic [P_CW-1:0] L_INIT3   = P_CW'(P_INIT3 - 1);
  localparam logic [P_CW-1:0] L_SETUP   = P_CW'(P_SETUP - 1);
  localparam logic [P_CW-1:0] L_PULSE   = P_CW'(P_PULSE - 1);
  localparam logic [P_CW-1:0] L_HOLD    = P_CW'(P_HOLD - 1);
  localparam logic [P_CW-1:0] L_GAP     = P_CW'(P_GAP - 1);
  localparam logic [P_CW-1:0] L_CMD     = P_CW'(P_CMD - 1);
  localparam logic [P_CW-1:0] L_CLEAR   = P_CW'(P_CLEAR - 1);

  lcdState_t       state;
  lcdState_t       stateNext;
  logic [P_CW-1:0] count;
  logic [P_CW-1:0] loadVal;
  logic [1:0]      initStep;
  logic [1:0]      stepNext;
  logic [7:0]      dataQ;
  logic            rsQ;
  logic            initDone;
  logic            accept;
  logic            countZero;
  logic            isClear;

  logic [7:0] dataNext;
  logic       rsNext;
  logic       readyNext;
  logic       eNext;
  logic       rsOutNext;
  logic [3:0] dNext;
  logic       doneNext;
  logic [3:0] initNibble;

  assign countZero = (count == '0);
  assign isClear   = !rsQ && (dataQ >= 8'h01) && (dataQ <= 8'h03);

  // State register plus the per-state wait counter; reset enters PWR_WAIT so the counter is loaded for it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_PWR_WAIT;
      count    <= L_POWERUP;
      initStep <= 2'd0;
      dataQ    <= 8'h00;
      rsQ      <= 1'b0;
      initDone <= 1'b0;
    end else begin
      state <= stateNext;
      if (stateNext != state) begin
        count <= loadVal;
      end else if (!countZero) begin
        count <= count - P_CW'(1);
      end
      initStep <= stepNext;
      if (accept) begin
        dataQ <= iData;
        rsQ   <= iRS;
      end
      initDone <= doneNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    stepNext  = initStep;
    case (state)
      S_PWR_WAIT:   if (countZero) stateNext = S_INIT_SETUP;
      S_INIT_SETUP: if (countZero) stateNext = S_INIT_PULSE;
      S_INIT_PULSE: if (countZero) stateNext = S_INIT_HOLD;
      S_INIT_HOLD:  if (countZero) stateNext = S_INIT_WAIT;
      S_INIT_WAIT: begin
        if (countZero) begin
          if (initStep == 2'd3) begin
            stateNext = S_IDLE;
          end else begin
            stateNext = S_INIT_SETUP;
            stepNext  = initStep + 2'd1;
          end
        end
      end
      S_IDLE: begin
        if (iValid) begin
          stateNext = S_SETUP_HI;
          accept    = 1'b1;
        end
      end
      S_SETUP_HI:   if (countZero) stateNext = S_PULSE_HI;
      S_PULSE_HI:   if (countZero) stateNext = S_HOLD_HI;
      S_HOLD_HI:    if (countZero) stateNext = S_GAP;
      S_GAP:        if (countZero) stateNext = S_SETUP_LO;
      S_SETUP_LO:   if (countZero) stateNext = S_PULSE_LO;
      S_PULSE_LO:   if (countZero) stateNext = S_HOLD_LO;
      S_HOLD_LO:    if (countZero) stateNext = S_POST;
      S_POST:       if (countZero) stateNext = S_IDLE;
      default:      stateNext = S_PWR_WAIT;
    endcase
  end

  // Duration of the state being entered, minus one.
  always_comb begin
    loadVal = '0;
    case (stateNext)
      S_PWR_WAIT:                          loadVal = L_POWERUP;
      S_INIT_SETUP, S_SETUP_HI, S_SETUP_LO: loadVal = L_SETUP;
      S_INIT_PULSE, S_PULSE_HI, S_PULSE_LO: loadVal = L_PULSE;
      S_INIT_HOLD, S_HOLD_HI, S_HOLD_LO:    loadVal = L_HOLD;
      S_GAP:                                loadVal = L_GAP;
      S_INIT_WAIT: begin
        case (initStep)
          2'd0:    loadVal = L_INIT1;
          2'd1:    loadVal = L_INIT2;
          default: loadVal = L_INIT3;
        endcase
      end
      S_POST:  loadVal = isClear ? L_CLEAR : L_CMD;
      default: loadVal = '0;
    endcase
  end

  // Next values of the registered pins, decoded from the state being entered.
  always_comb begin
    dataNext   = accept ? iData : dataQ;
    rsNext     = accept ? iRS : rsQ;
    initNibble = (stepNext == 2'd3) ? 4'h2 : 4'h3;
    readyNext  = (stateNext == S_IDLE);
    doneNext   = initDone || (stateNext == S_IDLE);
    eNext      = (stateNext == S_INIT_PULSE) || (stateNext == S_PULSE_HI) ||
                 (stateNext == S_PULSE_LO);
    rsOutNext  = 1'b0;
    dNext      = 4'h0;
    case (stateNext)
      S_PWR_WAIT: begin
        rsOutNext = 1'b0;
        dNext     = 4'h0;
      end
      S_INIT_SETUP, S_INIT_PULSE, S_INIT_HOLD, S_INIT_WAIT: begin
        rsOutNext = 1'b0;
        dNext     = initNibble;
      end
      S_IDLE: begin
        rsOutNext = oLCD_RS;
        dNext     = oLCD_D;
      end
      S_SETUP_HI, S_PULSE_HI, S_HOLD_HI, S_GAP: begin
        rsOutNext = rsNext;
        dNext     = dataNext[7:4];
      end
      default: begin
        rsOutNext = rsNext;
        dNext     = dataNext[3:0];
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      oReady    <= 1'b0;
      oInitDone <= 1'b0;
      oLCD_E    <= 1'b0;
      oLCD_RS   <= 1'b0;
      oLCD_D    <= 4'h0;
    end else begin
      oReady    <= readyNext;
      oInitDone <= doneNext;
      oLCD_E    <= eNext;
      oLCD_RS   <= rsOutNext;
      oLCD_D    <= dNext;
    end
  end

  assign oLCD_RW = 1'b0;
  assign oState  = state;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer using small timing parameters.
module tb_lcd_nibble_writer;

  logic       Clock;
  logic       Reset;
  logic [7:0] iData;
  logic       iRS;
  logic       iValid;
  logic       oReady;
  logic       oInitDone;
  logic       oLCD_E;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic [3:0] oLCD_D;
  logic [3:0] oState;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;
  int nAccepts = 0;

  lcd_nibble_writer #(
    .P_POWERUP(10), .P_INIT1(6), .P_INIT2(4), .P_INIT3(3),
    .P_SETUP(2), .P_PULSE(3), .P_HOLD(1), .P_GAP(2),
    .P_CMD(5), .P_CLEAR(9), .P_CW(20)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iData(iData), .iRS(iRS), .iValid(iValid),
    .oReady(oReady), .oInitDone(oInitDone), .oLCD_E(oLCD_E), .oLCD_RS(oLCD_RS),
    .oLCD_RW(oLCD_RW), .oLCD_D(oLCD_D), .oState(oState)
  );

  // Clock and reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (!Reset && iValid && oReady) nAccepts <= nAccepts + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for the next E pulse, checks its lead-in gap, nibble, RS and width.
  task automatic checkPulse(input string tag, input logic [3:0] expD, input logic expRS,
                            input int expGap);
    int n;
    int len;
    n = 0;
    while (!oLCD_E && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " gap"}, n, expGap);
    chk({tag, " d"}, oLCD_D, expD);
    chk({tag, " rs"}, oLCD_RS, expRS);
    chk({tag, " rw"}, oLCD_RW, 0);
    chk({tag, " ready"}, oReady, 0);
    len = 0;
    while (oLCD_E && len < 100) begin
      len++;
      tick();
    end
    chk({tag, " width"}, len, 3);
    chk({tag, " hold d"}, oLCD_D, expD);
  endtask

  task automatic waitReady(output int n);
    n = 0;
    while (!oReady && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Starts right after Reset is released.
  task automatic checkInit(input string tag);
    int n;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk({tag, " pwr quiet"}, {oLCD_E, oLCD_RS, oLCD_D, oReady, oInitDone}, 0);
    end
    checkPulse({tag, " n1"}, 4'h3, 1'b0, 3);
    checkPulse({tag, " n2"}, 4'h3, 1'b0, 9);
    checkPulse({tag, " n3"}, 4'h3, 1'b0, 7);
    checkPulse({tag, " n4"}, 4'h2, 1'b0, 6);
    chk({tag, " done early"}, oInitDone, 0);
    waitReady(n);
    chk({tag, " ready delay"}, n, 4);
    chk({tag, " initdone"}, oInitDone, 1);
  endtask

  task automatic doByte(input string tag, input logic [7:0] data, input logic rs,
                        input int expLat);
    int t0;
    int n;
    iData  = data;
    iRS    = rs;
    iValid = 1'b1;
    tick();
    t0     = cyc;
    iValid = 1'b0;
    chk({tag, " ready drop"}, oReady, 0);
    chk({tag, " setup rs"}, oLCD_RS, rs);
    checkPulse({tag, " hi"}, data[7:4], rs, 2);
    checkPulse({tag, " lo"}, data[3:0], rs, 5);
    waitReady(n);
    chk({tag, " latency"}, cyc - t0, expLat);
  endtask

  initial begin
    logic [7:0] burst [3];
    int t0;
    int n;
    int a0;
    int bad;
    burst[0] = 8'h48;
    burst[1] = 8'h49;
    burst[2] = 8'h21;

    // Power-on init
    Reset  = 1'b1;
    iValid = 1'b0;
    iData  = 8'h00;
    iRS    = 1'b0;
    repeat (3) tick();
    chk("reset e", oLCD_E, 0);
    chk("reset rs", oLCD_RS, 0);
    chk("reset rw", oLCD_RW, 0);
    chk("reset d", oLCD_D, 0);
    chk("reset ready", oReady, 0);
    chk("reset initdone", oInitDone, 0);
    Reset = 1'b0;
    checkInit("init");

    // Single character and POST length selection
    doByte("chr41", 8'h41, 1'b1, 19);
    doByte("cmd01", 8'h01, 1'b0, 23);
    doByte("chr01", 8'h01, 1'b1, 19);
    doByte("cmd00", 8'h00, 1'b0, 19);
    doByte("cmd03", 8'h03, 1'b0, 23);
    doByte("cmd04", 8'h04, 1'b0, 19);

    // Back-to-back with iValid held
    a0 = nAccepts;
    for (int i = 0; i < 3; i++) begin
      iData  = burst[i];
      iRS    = 1'b1;
      iValid = 1'b1;
      chk("burst idle ready", oReady, 1);
      tick();
      t0 = cyc;
      if (i == 2) iValid = 1'b0;
      chk("burst ready drop", oReady, 0);
      checkPulse("burst hi", burst[i][7:4], 1'b1, 2);
      checkPulse("burst lo", burst[i][3:0], 1'b1, 5);
      waitReady(n);
      chk("burst latency", cyc - t0, 19);
    end
    bad = 0;
    repeat (20) begin
      tick();
      if (oLCD_E || !oReady || oLCD_RW) bad++;
    end
    chk("burst quiet after", bad, 0);
    chk("burst accepts", nAccepts - a0, 3);

    // Reset during PULSE_LO, iValid held through the replayed init
    iData  = 8'h55;
    iRS    = 1'b1;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    checkPulse("abort hi", 4'h5, 1'b1, 2);
    n = 0;
    while (!oLCD_E && n < 50) begin
      tick();
      n++;
    end
    chk("abort lo gap", n, 5);
    Reset = 1'b1;
    tick();
    chk("abort e", oLCD_E, 0);
    chk("abort initdone", oInitDone, 0);
    chk("abort ready", oReady, 0);
    iData  = 8'h5A;
    iRS    = 1'b1;
    iValid = 1'b1;
    a0     = nAccepts;
    tick();
    Reset = 1'b0;
    checkInit("reinit");
    chk("reinit no accept", nAccepts - a0, 0);
    tick();
    t0     = cyc;
    iValid = 1'b0;
    chk("held accept", nAccepts - a0, 1);
    checkPulse("held hi", 4'h5, 1'b1, 2);
    checkPulse("held lo", 4'hA, 1'b1, 5);
    waitReady(n);
    chk("held latency", cyc - t0, 19);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
